// File: rtl/mcycle_unit.sv
// Iterative radix-2 multiply/divide unit with a destination tag, flush and divide-by-zero fast path.
// Returns the double-width product or the quotient and remainder, all through registered outputs.
module mcycle_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    input  logic [TAG_W-1:0] TagIn,
    input  logic             Flush,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic [TAG_W-1:0] TagOut,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, b_q;
    logic [TAG_W-1:0]   tag_q;
    logic               is_div_q, dz_q, sign_lo_q, sign_hi_q;

    logic               op_signed, op_div, s1, s2, div_zero_start, last_iter;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   rem_sub, hi_step, lo_step, fix_lo, fix_hi;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;

    assign op_signed      = MCycleOp[0];
    assign op_div         = MCycleOp[1];
    assign s1             = op_signed & Operand1[WIDTH-1];
    assign s2             = op_signed & Operand2[WIDTH-1];
    assign mag1           = s1 ? -Operand1 : Operand1;
    assign mag2           = s2 ? -Operand2 : Operand2;
    assign div_zero_start = op_div && (Operand2 == '0);
    assign last_iter      = (cnt_q == CNT_W'(WIDTH - 1));
    assign prod           = {acc_hi_q, acc_lo_q};

    // One radix-2 step. Multiply keeps the adder carry in the top of the accumulator;
    // divide compares the shifted partial remainder against the divisor one bit wider.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        hi_step   = acc_hi_q;
        lo_step   = acc_lo_q;
        mul_sum   = {1'b0, acc_hi_q} + {1'b0, b_q};
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        rem_sub   = div_shift[WIDTH-1:0] - b_q;
        if (is_div_q) begin
            hi_step = div_ge ? rem_sub : div_shift[WIDTH-1:0];
            lo_step = {acc_lo_q[WIDTH-2:0], div_ge};
        end else if (acc_lo_q[0]) begin
            {hi_step, lo_step} = {mul_sum, acc_lo_q[WIDTH-1:1]};
        end else begin
            {hi_step, lo_step} = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        fix_lo = acc_lo_q;
        fix_hi = acc_hi_q;
        if (dz_q) begin
            fix_lo = '1;
            fix_hi = acc_lo_q;  // raw dividend was parked here at capture
        end else if (is_div_q) begin
            fix_lo = sign_lo_q ? -acc_lo_q : acc_lo_q;
            fix_hi = sign_hi_q ? -acc_hi_q : acc_hi_q;
        end else if (sign_lo_q) begin
            {fix_hi, fix_lo} = -prod;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = div_zero_start ? FIX : ITER;
            ITER:    if (Flush) state_d = IDLE;
                     else if (last_iter) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        // NOTE: sequential state always uses non-blocking assignment so every register samples pre-edge values.
        else          state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            sign_lo_q <= 1'b0;
            sign_hi_q <= 1'b0;
            Result    <= '0;
            ResultHi  <= '0;
            TagOut    <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state_q)
                IDLE: if (Start) begin
                    Busy      <= 1'b1;
                    DivByZero <= 1'b0;
                    cnt_q     <= '0;
                    tag_q     <= TagIn;
                    is_div_q  <= op_div;
                    dz_q      <= div_zero_start;
                    sign_lo_q <= s1 ^ s2;
                    sign_hi_q <= s1;
                    acc_hi_q  <= '0;
                    acc_lo_q  <= div_zero_start ? Operand1 : (op_div ? mag1 : mag2);
                    b_q       <= op_div ? mag2 : mag1;
                end
                ITER: if (Flush) begin
                    Busy <= 1'b0;
                end else begin
                    acc_hi_q <= hi_step;
                    acc_lo_q <= lo_step;
                    cnt_q    <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    Busy <= 1'b0;
                    if (!Flush) begin
                        Result    <= fix_lo;
                        ResultHi  <= fix_hi;
                        TagOut    <= tag_q;
                        Done      <= 1'b1;
                        DivByZero <= dz_q;
                    end
                end
                default: Busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed bench for mcycle_unit: a vector table of single operations plus hand-written
// sequences for back-to-back issue, flush and asynchronous reset.
module tb_mcycle_unit;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int LIMIT = 100;

    logic             CLK = 1'b0;
    logic             Reset_n, Start, Flush;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1, Operand2;
    logic [TAG_W-1:0] TagIn;
    logic [WIDTH-1:0] Result, ResultHi;
    logic [TAG_W-1:0] TagOut;
    logic             Busy, Done, DivByZero;

    int errors = 0;
    int checks = 0;

    mcycle_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2), .TagIn(TagIn), .Flush(Flush),
        .Result(Result), .ResultHi(ResultHi), .TagOut(TagOut),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] a, b;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] lo, hi;
        logic             dz;
        int               lat;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one request on a falling edge; returns on the falling edge right after capture.
    task automatic start_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [TAG_W-1:0] tag);
        @(negedge CLK);
        MCycleOp = op; Operand1 = a; Operand2 = b; TagIn = tag; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0; Operand1 = $urandom; Operand2 = $urandom;
    endtask

    // Counts rising edges after capture until Done is seen, and the cycles Busy was high.
    task automatic wait_done(output int edges, output int busy_n);
        edges = 0; busy_n = 0;
        while (1) begin
            if (Busy) busy_n++;
            if (Done || edges >= LIMIT) break;
            @(negedge CLK);
            edges++;
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge CLK);
            if (Done) n++;
        end
    endtask

    initial begin
        int e, bz, n;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5,  32'h00000001, 32'hFFFFFFFE, 1'b0, 33};
        vecs[1]  = '{2'b01, 32'hFFFFFFF9, 32'h00000006, 4'd1,  32'hFFFFFFD6, 32'hFFFFFFFF, 1'b0, 33};
        vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 4'd2,  32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
        vecs[3]  = '{2'b10, 32'd100,      32'd0,        4'd3,  32'hFFFFFFFF, 32'd100,      1'b1, 1};
        vecs[4]  = '{2'b10, 32'd100,      32'd7,        4'd4,  32'd14,       32'd2,        1'b0, 33};
        vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 4'd6,  32'h80000000, 32'h00000000, 1'b0, 33};
        vecs[6]  = '{2'b11, 32'hFFFFFF9C, 32'd0,        4'd7,  32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1, 1};
        vecs[7]  = '{2'b01, 32'h80000000, 32'h80000000, 4'd8,  32'h00000000, 32'h40000000, 1'b0, 33};
        vecs[8]  = '{2'b11, 32'd100,      32'hFFFFFFF9, 4'd9,  32'hFFFFFFF2, 32'd2,        1'b0, 33};
        vecs[9]  = '{2'b00, 32'h12345678, 32'h00000010, 4'd10, 32'h23456780, 32'h00000001, 1'b0, 33};
        vecs[10] = '{2'b10, 32'd7,        32'h10,       4'd11, 32'd0,        32'd7,        1'b0, 33};
        vecs[11] = '{2'b11, 32'hFFFFFF9C, 32'd7,        4'd12, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33};

        Reset_n = 1'b0; Start = 1'b0; Flush = 1'b0; MCycleOp = 2'b00;
        Operand1 = '0; Operand2 = '0; TagIn = '0;
        #12;
        check("rst Result", Result, 0);
        check("rst ResultHi", ResultHi, 0);
        check("rst TagOut", TagOut, 0);
        check("rst Busy", Busy, 0);
        check("rst Done", Done, 0);
        check("rst DivByZero", DivByZero, 0);
        @(negedge CLK);
        Reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            check($sformatf("v%0d dz_clear", i), DivByZero, 0);
            check($sformatf("v%0d busy_on", i), Busy, 1);
            wait_done(e, bz);
            check($sformatf("v%0d latency", i), e, vecs[i].lat);
            check($sformatf("v%0d busy_cycles", i), bz, vecs[i].lat);
            check($sformatf("v%0d Result", i), Result, vecs[i].lo);
            check($sformatf("v%0d ResultHi", i), ResultHi, vecs[i].hi);
            check($sformatf("v%0d TagOut", i), TagOut, vecs[i].tag);
            check($sformatf("v%0d DivByZero", i), DivByZero, vecs[i].dz);
            @(negedge CLK);
            check($sformatf("v%0d done_pulse", i), Done, 0);
            check($sformatf("v%0d hold", i), Result, vecs[i].lo);
        end

        // Start held high: the second request is taken in the first one's Done cycle.
        @(negedge CLK);
        MCycleOp = 2'b00; Operand1 = 32'd3; Operand2 = 32'd4; TagIn = 4'd1; Start = 1'b1;
        @(negedge CLK);
        Operand1 = 32'd5; Operand2 = 32'd6; TagIn = 4'd2;
        wait_done(e, bz);
        check("b2b first latency", e, WIDTH + 1);
        check("b2b first Result", Result, 12);
        check("b2b first TagOut", TagOut, 1);
        @(negedge CLK);
        check("b2b accept Busy", Busy, 1);
        wait_done(e, bz);
        Start = 1'b0;
        check("b2b second latency", e, WIDTH + 1);
        check("b2b second Result", Result, 30);
        check("b2b second TagOut", TagOut, 2);
        count_dones(40, n);
        check("b2b extra dones", n, 0);

        // Flush in the tenth ITER cycle discards the operation and keeps prior outputs.
        start_op(2'b00, 32'd9, 32'd9, 4'd12);
        repeat (9) @(negedge CLK);
        Flush = 1'b1;
        @(negedge CLK);
        Flush = 1'b0;
        check("flush Busy", Busy, 0);
        check("flush Done", Done, 0);
        check("flush Result", Result, 30);
        check("flush TagOut", TagOut, 2);
        count_dones(40, n);
        check("flush no Done", n, 0);

        // Flush together with Start in IDLE: the request is still accepted.
        Flush = 1'b1;
        start_op(2'b10, 32'd50, 32'd5, 4'd13);
        Flush = 1'b0;
        check("flush+start Busy", Busy, 1);
        wait_done(e, bz);
        check("flush+start latency", e, WIDTH + 1);
        check("flush+start Result", Result, 10);
        check("flush+start ResultHi", ResultHi, 0);
        check("flush+start TagOut", TagOut, 13);

        // Asynchronous reset mid-ITER clears outputs without waiting for a clock edge.
        start_op(2'b01, 32'd2, 32'd3, 4'd14);
        repeat (5) @(negedge CLK);
        #2 Reset_n = 1'b0;
        #1;
        check("arst Result", Result, 0);
        check("arst TagOut", TagOut, 0);
        check("arst Busy", Busy, 0);
        @(negedge CLK);
        Reset_n = 1'b1;
        count_dones(3, n);
        check("arst no Done", n, 0);
        start_op(2'b00, 32'd2, 32'd3, 4'd15);
        wait_done(e, bz);
        check("post-rst latency", e, WIDTH + 1);
        check("post-rst Result", Result, 6);
        check("post-rst TagOut", TagOut, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
